// File: rtl/gates_pkg.sv
// gates_pkg: lane map, reference lane functions and BIST state encoding
package gates_pkg;
  localparam int LANE_AND  = 0;
  localparam int LANE_OR   = 1;
  localparam int LANE_NOT  = 2;
  localparam int LANE_NAND = 3;
  localparam int LANE_NOR  = 4;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} bist_state_t;
  function automatic logic [4:0] gates_expected(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] y;
    y[LANE_AND]  = a[LANE_AND] & b[LANE_AND];
    y[LANE_OR]   = a[LANE_OR] | b[LANE_OR];
    y[LANE_NOT]  = ~a[LANE_NOT];
    y[LANE_NAND] = ~(a[LANE_NAND] & b[LANE_NAND]);
    y[LANE_NOR]  = ~(a[LANE_NOR] | b[LANE_NOR]);
    return y;
  endfunction
endpackage

// File: rtl/gates_bist_if.sv
// gates_bist_if: run control, gates stimulus/response and result bundle of the BIST
interface gates_bist_if;
  logic        start;
  logic [4:0]  a_out;
  logic [4:0]  b_out;
  logic [4:0]  y_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic [4:0]  fail_lane_mask;
  logic [15:0] first_fail_idx;
  modport master (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_lane_mask, first_fail_idx
  );
  modport slave (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_lane_mask, first_fail_idx
  );
endinterface

// File: rtl/gates_lfsr16.sv
// gates_lfsr16: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left
module gates_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);
  logic [15:0] state_q, state_d;
  always_comb state_d = (rst || load) ? seed :
                        step ? {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]} :
                        state_q;
  always_ff @(posedge clk) state_q <= state_d;
  assign state = state_q;
endmodule

// File: rtl/gates_bist.sv
// gates_bist: drives LFSR vectors into the gates block and scores the returned y
module gates_bist
  import gates_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 32,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  gates_bist_if.master bus
);
  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  bist_state_t state_q, state_d;
  logic [15:0] vec_q, vec_d, ffi_q, ffi_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  a_q, a_d, b_q, b_d, mask_q, mask_d, mism;
  logic [7:0]  err_q, err_d;
  logic [9:0]  lfsr_lo;
  logic [5:0]  unused_lfsr_hi;
  logic        accept;
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);
  assign mism   = bus.y_in ^ gates_expected(a_q, b_q);
  gates_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (LFSR_SEED),
    .step  (state_q == DRIVE),
    .state ({unused_lfsr_hi, lfsr_lo})
  );
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ffi_d   = ffi_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: if (accept) begin
        state_d = DRIVE;
        vec_d   = '0;
        err_d   = '0;
        mask_d  = '0;
        ffi_d   = '0;
      end
      DRIVE: begin
        a_d     = lfsr_lo[4:0];
        b_d     = lfsr_lo[9:5];
        cnt_d   = SETTLE_LAST;
        state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      end
      SETTLE: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? CHECK : SETTLE;
      end
      CHECK: begin
        // err_q==0 marks the first failure of this run
        if (mism != 5'd0) begin
          err_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          mask_d = mask_q | mism;
          ffi_d  = (err_q == 8'd0) ? vec_q : ffi_q;
        end
        state_d = (vec_q == LAST_IDX) ? DONE : DRIVE;
        vec_d   = (vec_q == LAST_IDX) ? vec_q : vec_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      ffi_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ffi_q   <= ffi_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end
  assign bus.a_out          = a_q;
  assign bus.b_out          = b_q;
  assign bus.busy           = state_q == DRIVE || state_q == SETTLE || state_q == CHECK;
  assign bus.done           = state_q == DONE;
  assign bus.pass           = state_q == DONE && err_q == 8'd0;
  assign bus.err_count      = err_q;
  assign bus.fail_lane_mask = mask_q;
  assign bus.first_fail_idx = ffi_q;
endmodule

// File: doc/gates_bist.md
Name: gates_bist

Overview:
Built-in self-test driver and checker for the 5-lane gates block (lane functions: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR).
- Transmit side: generates pseudo-random a/b vectors from an LFSR and drives them onto the gates inputs.
- Receive side: samples the returned y, compares it against the expected lane functions and accumulates pass/fail statistics.
- Sits beside the gates instance at subsystem level and replaces testbench-only random stimulus with a synthesizable one.

Parameters:
NUM_VECTORS, 32, vectors per run (1..65535)
SETTLE_CYCLES, 1, idle cycles between driving a/b and sampling y (0..15)
LFSR_SEED, 16'hACE1, LFSR load value at each start (nonzero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  run request, sampled in IDLE and DONE only
a_out  out  5  operand a to gates block
b_out  out  5  operand b to gates block
y_in  in  5  result from gates block
busy  out  1  high in DRIVE/SETTLE/CHECK
done  out  1  high in DONE
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  8  failing-vector count, saturates at 255
fail_lane_mask  out  5  sticky OR of per-lane mismatches
first_fail_idx  out  16  index of first failing vector; meaningful only when err_count!=0

Behaviour:
- Reset: all outputs 0, FSM=IDLE, LFSR=LFSR_SEED, vector counter=0. rst has priority over every other event, including mid-run; no partial statistics survive.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE, start=1 -> DRIVE. On that edge: LFSR<=LFSR_SEED, vec_idx<=0, err_count/mask/first_fail_idx<=0.
- DRIVE: a_out<=lfsr[4:0], b_out<=lfsr[9:5], LFSR steps once. Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: down-counter runs SETTLE_CYCLES cycles, then -> CHECK.
- CHECK:
  - Compute expected y from the registered a_out/b_out; mism = y_in ^ expected.
  - If mism!=0: err_count += 1 (saturating at 255), fail_lane_mask |= mism. If this is the first failure of the run, first_fail_idx <= vec_idx.
  - If vec_idx==NUM_VECTORS-1 -> DONE, else vec_idx += 1 -> DRIVE.
- DONE: done=1, pass=(err_count==0). Results hold.
  - start=1 -> DRIVE with the same clear/reload as from IDLE; done and pass drop next cycle.
- start while busy is ignored.
- a_out/b_out hold their last vector in DONE and IDLE (0 after reset).
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0. Vector k (k=0,1,...) uses LFSR state after k steps from the seed.
- Latency: per vector 2+SETTLE_CYCLES cycles. done rises NUM_VECTORS*(2+SETTLE_CYCLES) cycles after the edge that accepts start.
- Width rules: lane mapping is fixed at 5 lanes. vec_idx is 16 bits. Saturated err_count does not wrap.

Decomposition:
- Shared package gates_pkg:
  - lane index constants LANE_AND=0, LANE_OR=1, LANE_NOT=2, LANE_NAND=3, LANE_NOR=4
  - function gates_expected(a,b) returning the 5-bit y, reused by the gates RTL and benches
  - enum bist_state_t {IDLE, DRIVE, SETTLE, CHECK, DONE}
- One sub-module: gates_lfsr16 (ports: clk, rst, load, seed, step, state).

Test Plan:
- Reset, then start with a correct gates model, defaults -> first a_out=5'h01, b_out=5'h07, y=5'h1F. done 96 cycles after start; pass=1, err_count=0, mask=0.
- gates model with lane 3 stuck-at-0 -> vector 0 fails (expected y[3]=1), first_fail_idx=0, fail_lane_mask=5'b01000, pass=0. err_count equals the reference count of vectors with ~(a3&b3)=1.
- Inverting model (y_in = ~expected), NUM_VECTORS=300 -> err_count=255 (saturated), fail_lane_mask=5'h1F, first_fail_idx=0.
- Pulse start again at cycle 5 of a run -> ignored, run length unchanged. Then assert rst at cycle 10 -> next cycle busy=0, all outputs 0. A new start replays the first vector 01/07.
- SETTLE_CYCLES=0, NUM_VECTORS=1 -> done 2 cycles after start. start in DONE -> done=0 next cycle, rerun gives identical results.
